// File: rtl/dmem_port_arbiter.sv
// Single data-RAM port shared by the CPU MEM stage (priority) and a DMA/loader requester.
// A consecutive-denial counter forces a DMA grant so the DMA cannot be starved.
module dmem_port_arbiter #(
  parameter int MAX_WAIT = 8,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  localparam int CNT_W   = $clog2(MAX_WAIT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [2:0]        cpu_funct3,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req_valid,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic [2:0]        dma_funct3,
  output logic              dma_req_ready,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_writeData,
  output logic [2:0]        ram_funct3,
  output logic              ram_memRead,
  output logic              ram_memWrite,
  input  logic [DATA_W-1:0] ram_readData,
  output logic              dbgState,
  output logic [CNT_W-1:0]  dbgWaitCnt
);

  // Handshake: a DMA transfer happens in exactly the cycle where dma_req_valid and
  // dma_req_ready are both high; the CPU side has no ready, it is held off by cpu_stall.
  typedef enum logic {PRI_CPU = 1'b0, FORCE_DMA = 1'b1} arbStateT;

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

  arbStateT         state, nextState;
  logic [CNT_W-1:0] waitCnt, nextWaitCnt;
  logic             cpuGrant, dmaGrant;

  always_comb begin
    cpuGrant      = 1'b0;
    dmaGrant      = 1'b0;
    ram_address   = '0;
    ram_writeData = '0;
    ram_funct3    = '0;
    ram_memRead   = 1'b0;
    ram_memWrite  = 1'b0;
    nextState     = state;
    nextWaitCnt   = waitCnt;

    if (!rst) begin
      if (state == FORCE_DMA && dma_req_valid) dmaGrant = 1'b1;
      else if (cpu_req_valid)                  cpuGrant = 1'b1;
      else if (dma_req_valid)                  dmaGrant = 1'b1;
    end

    if (cpuGrant) begin
      ram_address   = cpu_addr;
      ram_writeData = cpu_wdata;
      ram_funct3    = cpu_funct3;
      ram_memRead   = ~cpu_we;
      ram_memWrite  = cpu_we;
    end else if (dmaGrant) begin
      ram_address   = dma_addr;
      ram_writeData = dma_wdata;
      ram_funct3    = dma_funct3;
      ram_memRead   = ~dma_we;
      ram_memWrite  = dma_we;
    end

    // Served or withdrawn DMA ends the wait; otherwise count the denial.
    if (dmaGrant || !dma_req_valid) begin
      nextWaitCnt = '0;
      nextState   = PRI_CPU;
    end else begin
      if (waitCnt != MAX_CNT) nextWaitCnt = waitCnt + CNT_W'(1);
      if (state == PRI_CPU && waitCnt == LAST_CNT) nextState = FORCE_DMA;
    end
  end

  assign cpu_stall     = cpu_req_valid & ~cpuGrant;
  assign dma_req_ready = dmaGrant;
  assign dbgState      = (state == FORCE_DMA);
  assign dbgWaitCnt    = waitCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PRI_CPU;
      waitCnt    <= '0;
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
    end else begin
      state      <= nextState;
      waitCnt    <= nextWaitCnt;
      cpu_rvalid <= cpuGrant & ~cpu_we;
      dma_rvalid <= dmaGrant & ~dma_we;
      if (cpuGrant && !cpu_we) cpu_rdata <= ram_readData;
      if (dmaGrant && !dma_we) dma_rdata <= ram_readData;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus a randomized run against a
// behavioural model built on a consecutive-denial streak count and expected-data queues.
module tb_dmem_port_arbiter;
  localparam int MAX_WAIT = 8;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req_valid, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [2:0]  cpu_funct3;
  logic        cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dma_req_valid, dma_we;
  logic [31:0] dma_addr, dma_wdata;
  logic [2:0]  dma_funct3;
  logic        dma_req_ready, dma_rvalid;
  logic [31:0] dma_rdata;
  logic [31:0] ram_address, ram_writeData, ram_readData;
  logic [2:0]  ram_funct3;
  logic        ram_memRead, ram_memWrite;
  logic        dbg_state;
  logic [CNT_W-1:0] dbg_wait_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [0:255];

  dmem_port_arbiter #(.MAX_WAIT(MAX_WAIT), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_funct3(cpu_funct3), .cpu_stall(cpu_stall),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req_valid(dma_req_valid), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_funct3(dma_funct3), .dma_req_ready(dma_req_ready),
    .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .ram_address(ram_address), .ram_writeData(ram_writeData), .ram_funct3(ram_funct3),
    .ram_memRead(ram_memRead), .ram_memWrite(ram_memWrite), .ram_readData(ram_readData),
    .dbgState(dbg_state), .dbgWaitCnt(dbg_wait_cnt)
  );

  // ---------------- clock / RAM model ----------------
  always #5 clk = ~clk;

  function automatic logic [31:0] ram_read(input logic [31:0] a, input logic [2:0] f3);
    int i;
    i = int'(a[7:0]);
    case (f3)
      3'b000:  return {{24{mem[i][7]}}, mem[i]};
      3'b001:  return {{16{mem[i+1][7]}}, mem[i+1], mem[i]};
      3'b010:  return {mem[i+3], mem[i+2], mem[i+1], mem[i]};
      3'b100:  return {24'h0, mem[i]};
      3'b101:  return {16'h0, mem[i+1], mem[i]};
      default: return 32'h0;
    endcase
  endfunction

  always_comb ram_readData = ram_read(ram_address, ram_funct3);

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);
    {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]} = 32'hDEADBEEF;
    {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]} = 32'h12345678;
    {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]} = 32'hFFFFFFFF;
    forever begin
      @(posedge clk);
      if (ram_memWrite) begin
        case (ram_funct3)
          3'b000: mem[int'(ram_address[7:0])] = ram_writeData[7:0];
          3'b001: {mem[int'(ram_address[7:0])+1], mem[int'(ram_address[7:0])]} = ram_writeData[15:0];
          default: {mem[int'(ram_address[7:0])+3], mem[int'(ram_address[7:0])+2],
                    mem[int'(ram_address[7:0])+1], mem[int'(ram_address[7:0])]} = ram_writeData;
        endcase
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    cpu_req_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_funct3 = '0;
    dma_req_valid = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0; dma_funct3 = '0;
  endtask

  task automatic drive_cpu(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    cpu_req_valid = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_funct3 = f3;
  endtask

  task automatic drive_dma(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    dma_req_valid = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d; dma_funct3 = f3;
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    drive_cpu(1'b0, 32'h10, 32'h0, 3'b010);
    @(negedge clk);
    n_checks++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL rst_stall: got %b want 1", cpu_stall); end
    n_checks++; if ({ram_memRead, ram_memWrite, dma_req_ready} !== 3'b000) begin n_fail++; $display("FAIL rst_nogrant: got %b want 000", {ram_memRead, ram_memWrite, dma_req_ready}); end
    tick();
    drive_idle();
    tick();
    rst = 1'b0;
    n_checks++; if ({cpu_rvalid, dma_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rst_rvalid: got %b want 00", {cpu_rvalid, dma_rvalid}); end
    n_checks++; if (cpu_rdata !== 32'h0 || dma_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h/%h want 0/0", cpu_rdata, dma_rdata); end
    n_checks++; if (dbg_state !== 1'b0 || dbg_wait_cnt !== '0) begin n_fail++; $display("FAIL rst_state: got %b/%0d want 0/0", dbg_state, dbg_wait_cnt); end
  endtask

  task automatic test_cpu_load();
    drive_cpu(1'b0, 32'h10, 32'h0, 3'b010);
    @(negedge clk);
    n_checks++; if (ram_memRead !== 1'b1 || ram_address !== 32'h10) begin n_fail++; $display("FAIL ld_ram: got rd=%b addr=%h want 1/10", ram_memRead, ram_address); end
    n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL ld_stall: got %b want 0", cpu_stall); end
    tick();
    drive_idle();
    n_checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ld_resp: got %b/%h want 1/deadbeef", cpu_rvalid, cpu_rdata); end
    tick();
    n_checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ld_hold: got %b/%h want 0/deadbeef", cpu_rvalid, cpu_rdata); end
  endtask

  task automatic test_starvation();
    drive_cpu(1'b0, 32'h10, 32'h0, 3'b010);
    drive_dma(1'b0, 32'h20, 32'h0, 3'b010);
    for (int i = 0; i < MAX_WAIT; i++) begin
      @(negedge clk);
      n_checks++; if (dma_req_ready !== 1'b0 || cpu_stall !== 1'b0 || ram_address !== 32'h10) begin
        n_fail++; $display("FAIL starve_deny%0d: got rdy=%b stall=%b addr=%h want 0/0/10", i, dma_req_ready, cpu_stall, ram_address);
      end
      tick();
    end
    @(negedge clk);
    n_checks++; if (dbg_state !== 1'b1 || dbg_wait_cnt !== CNT_W'(MAX_WAIT)) begin n_fail++; $display("FAIL starve_force: got %b/%0d want 1/%0d", dbg_state, dbg_wait_cnt, MAX_WAIT); end
    n_checks++; if (dma_req_ready !== 1'b1 || cpu_stall !== 1'b1) begin n_fail++; $display("FAIL starve_grant: got rdy=%b stall=%b want 1/1", dma_req_ready, cpu_stall); end
    n_checks++; if (ram_address !== 32'h20 || ram_memRead !== 1'b1) begin n_fail++; $display("FAIL starve_ram: got %h/%b want 20/1", ram_address, ram_memRead); end
    tick();
    dma_req_valid = 1'b0;
    n_checks++; if (dma_rvalid !== 1'b1 || dma_rdata !== 32'h12345678) begin n_fail++; $display("FAIL starve_dresp: got %b/%h want 1/12345678", dma_rvalid, dma_rdata); end
    n_checks++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL starve_crv: got %b want 0", cpu_rvalid); end
    n_checks++; if (dbg_state !== 1'b0 || dbg_wait_cnt !== '0) begin n_fail++; $display("FAIL starve_back: got %b/%0d want 0/0", dbg_state, dbg_wait_cnt); end
    @(negedge clk);
    n_checks++; if (cpu_stall !== 1'b0 || ram_address !== 32'h10) begin n_fail++; $display("FAIL starve_regain: got %b/%h want 0/10", cpu_stall, ram_address); end
    tick();
    drive_idle();
    n_checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL starve_cresp: got %b/%h want 1/deadbeef", cpu_rvalid, cpu_rdata); end
  endtask

  task automatic test_dma_write();
    drive_dma(1'b1, 32'h40, 32'h0000_00AB, 3'b000);
    @(negedge clk);
    n_checks++; if (dma_req_ready !== 1'b1 || ram_memWrite !== 1'b1 || ram_memRead !== 1'b0) begin n_fail++; $display("FAIL dwr_ctl: got rdy=%b wr=%b rd=%b want 1/1/0", dma_req_ready, ram_memWrite, ram_memRead); end
    n_checks++; if (ram_address !== 32'h40 || ram_writeData !== 32'hAB || ram_funct3 !== 3'b000) begin n_fail++; $display("FAIL dwr_bus: got %h/%h/%0d want 40/ab/0", ram_address, ram_writeData, ram_funct3); end
    tick();
    drive_idle();
    n_checks++; if (dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL dwr_rvalid: got %b want 0", dma_rvalid); end
    drive_cpu(1'b0, 32'h40, 32'h0, 3'b100);
    tick();
    drive_idle();
    n_checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h0000_00AB) begin n_fail++; $display("FAIL dwr_lbu: got %b/%h want 1/000000ab", cpu_rvalid, cpu_rdata); end
  endtask

  task automatic test_withdraw();
    drive_cpu(1'b0, 32'h10, 32'h0, 3'b010);
    drive_dma(1'b1, 32'h80, 32'h55, 3'b010);
    repeat (MAX_WAIT) tick();
    dma_req_valid = 1'b0;
    n_checks++; if (dbg_state !== 1'b1) begin n_fail++; $display("FAIL wd_forced: got %b want 1", dbg_state); end
    @(negedge clk);
    n_checks++; if (dma_req_ready !== 1'b0 || cpu_stall !== 1'b0 || ram_memWrite !== 1'b0) begin n_fail++; $display("FAIL wd_grant: got rdy=%b stall=%b wr=%b want 0/0/0", dma_req_ready, cpu_stall, ram_memWrite); end
    n_checks++; if (ram_address !== 32'h10 || ram_memRead !== 1'b1) begin n_fail++; $display("FAIL wd_ram: got %h/%b want 10/1", ram_address, ram_memRead); end
    tick();
    drive_idle();
    n_checks++; if (dbg_state !== 1'b0 || dbg_wait_cnt !== '0 || dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL wd_back: got %b/%0d/%b want 0/0/0", dbg_state, dbg_wait_cnt, dma_rvalid); end
  endtask

  task automatic test_reset_mid();
    drive_cpu(1'b0, 32'h10, 32'h0, 3'b010);
    drive_dma(1'b0, 32'h20, 32'h0, 3'b010);
    repeat (3) tick();
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    n_checks++; if (ram_memRead !== 1'b0 || ram_memWrite !== 1'b0) begin n_fail++; $display("FAIL rm_ram: got %b/%b want 0/0", ram_memRead, ram_memWrite); end
    tick();
    rst = 1'b0;
    n_checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL rm_resp: got %b/%h want 0/0", cpu_rvalid, cpu_rdata); end
    n_checks++; if (dbg_state !== 1'b0 || dbg_wait_cnt !== '0) begin n_fail++; $display("FAIL rm_state: got %b/%0d want 0/0", dbg_state, dbg_wait_cnt); end
  endtask

  // ---------------- randomized run with reference model ----------------
  task automatic test_random();
    logic [31:0] exp_cpu_q[$];
    logic [31:0] exp_dma_q[$];
    logic [31:0] last_cpu, last_dma, e_addr, e_wdata;
    logic [2:0]  rd_f3 [5];
    logic [2:0]  e_f3;
    logic        e_v, forced, cg, dg, e_rd, e_wr, cpu_hold, dma_hold;
    int          streak;
    rd_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    drive_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    streak = 0; last_cpu = '0; last_dma = '0; cpu_hold = 1'b0; dma_hold = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      e_v = (exp_cpu_q.size() > 0);
      if (e_v) last_cpu = exp_cpu_q.pop_front();
      n_checks++; if (cpu_rvalid !== e_v || cpu_rdata !== last_cpu) begin n_fail++; $display("FAIL rnd_cpu_resp c%0d: got %b/%h want %b/%h", c, cpu_rvalid, cpu_rdata, e_v, last_cpu); end
      e_v = (exp_dma_q.size() > 0);
      if (e_v) last_dma = exp_dma_q.pop_front();
      n_checks++; if (dma_rvalid !== e_v || dma_rdata !== last_dma) begin n_fail++; $display("FAIL rnd_dma_resp c%0d: got %b/%h want %b/%h", c, dma_rvalid, dma_rdata, e_v, last_dma); end

      rst = ($urandom_range(0, 39) == 0);
      if (!cpu_hold) begin
        cpu_req_valid = ($urandom_range(0, 9) < 7);
        cpu_we        = 1'($urandom_range(0, 1));
        cpu_addr      = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        cpu_wdata     = $urandom;
        cpu_funct3    = cpu_we ? 3'($urandom_range(0, 2)) : rd_f3[$urandom_range(0, 4)];
      end
      if (!dma_hold) begin
        dma_req_valid = ($urandom_range(0, 1) == 1);
        dma_we        = 1'($urandom_range(0, 1));
        dma_addr      = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        dma_wdata     = $urandom;
        dma_funct3    = dma_we ? 3'($urandom_range(0, 2)) : rd_f3[$urandom_range(0, 4)];
      end
      @(negedge clk);
      // DMA wins when it has been refused MAX_WAIT cycles in a row; otherwise CPU first.
      forced = !rst && dma_req_valid && (streak >= MAX_WAIT);
      cg = !rst && cpu_req_valid && !forced;
      dg = !rst && dma_req_valid && !cg;
      e_addr = cg ? cpu_addr : (dg ? dma_addr : 32'h0);
      e_wdata = cg ? cpu_wdata : (dg ? dma_wdata : 32'h0);
      e_f3 = cg ? cpu_funct3 : (dg ? dma_funct3 : 3'b000);
      e_rd = (cg && !cpu_we) || (dg && !dma_we);
      e_wr = (cg && cpu_we) || (dg && dma_we);
      n_checks++; if (cpu_stall !== (cpu_req_valid && !cg) || dma_req_ready !== dg) begin n_fail++; $display("FAIL rnd_grant c%0d: got stall=%b rdy=%b want %b/%b", c, cpu_stall, dma_req_ready, cpu_req_valid && !cg, dg); end
      n_checks++; if (ram_memRead !== e_rd || ram_memWrite !== e_wr) begin n_fail++; $display("FAIL rnd_ctl c%0d: got %b/%b want %b/%b", c, ram_memRead, ram_memWrite, e_rd, e_wr); end
      n_checks++; if (ram_address !== e_addr || ram_writeData !== e_wdata || ram_funct3 !== e_f3) begin n_fail++; $display("FAIL rnd_bus c%0d: got %h/%h/%0d want %h/%h/%0d", c, ram_address, ram_writeData, ram_funct3, e_addr, e_wdata, e_f3); end
      if (cg && !cpu_we) exp_cpu_q.push_back(ram_read(cpu_addr, cpu_funct3));
      if (dg && !dma_we) exp_dma_q.push_back(ram_read(dma_addr, dma_funct3));
      if (rst) begin last_cpu = '0; last_dma = '0; end
      streak = (rst || !dma_req_valid || dg) ? 0 : streak + 1;
      cpu_hold = cpu_req_valid && !cg;
      dma_hold = dma_req_valid && !dg;
      tick();
    end
    rst = 1'b0;
    drive_idle();
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    #1;
    test_reset();
    test_cpu_load();
    test_starvation();
    test_dma_write();
    test_withdraw();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
